pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the ID/EX pipeline register and its neighbours: detects load-use hazards,
//  branch-taken flushes and multi-cycle data-memory waits. Drives the write enables and
//  bubble/flush controls of PC, IF/ID, ID/EX and EX/MEM. Sits beside the ID stage and
//  arbitrates between competing stall/flush causes with a fixed priority.
// PARAMETERS
//  FLUSH_CYCLES   1  cycles ID/EX+EX/MEM are bubbled after branch taken (1..15)
//  LU_CYCLES      1  load-use stall length in cycles (1..15)
//  MEM_TIMEOUT    0  max MEM_WAIT cycles before err pulse; 0 = no timeout (0..255)
// PORTS
//  clk            in   1   pipeline clock
//  rst            in   1   async reset, active-high
//  id_rs          in   5   IF/ID instr[25:21]
//  id_rt          in   5   IF/ID instr[20:16]
//  id_uses_rt     in   1   decoded instr reads rt as source
//  ex_MemRead     in   1   ID/EX MemRead output
//  ex_rt          in   5   ID/EX instr_bits_20_16 output (load destination)
//  mem_branch_taken in 1   branch resolved taken in MEM stage
//  dmem_req       in   1   data memory access in progress from MEM stage
//  dmem_ready     in   1   data memory completes this cycle
//  pc_we          out  1   PC update enable
//  ifid_we        out  1   IF/ID load enable
//  ifid_flush     out  1   IF/ID clear to NOP
//  idex_we        out  1   ID/EX load enable
//  idex_bubble    out  1   load zeros into all ID/EX control bits (RegWrite..Branch,ALUOp)
//  exmem_bubble   out  1   zero EX/MEM control bits
//  state          out  2   FSM state (debug)
//  mem_timeout_err out 1   one-cycle pulse on MEM_WAIT timeout
// BEHAVIOUR
//  - Reset (async, rst=1): state=RUN, counters=0; outputs forced idle: pc_we=ifid_we=idex_we=1,
//    ifid_flush=idex_bubble=exmem_bubble=0, mem_timeout_err=0. Reset mid-stall aborts it.
//  - hazard = ex_MemRead & (ex_rt!=0) & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
//  - Outputs are Mealy: causes detected in RUN act in the same cycle, no added latency.
//  - States: RUN=0, LU_STALL=1, FLUSH=2, MEM_WAIT=3. Priority in RUN: mem wait > branch > hazard.
//  - RUN, dmem_req & !dmem_ready: freeze: pc_we=ifid_we=idex_we=0, no bubbles; -> MEM_WAIT.
//  - RUN, mem_branch_taken: pc_we=1, ifid_flush=1, idex_bubble=1, exmem_bubble=1;
//    FLUSH_CYCLES>1 -> FLUSH, cnt=FLUSH_CYCLES-1; else stay RUN. Pending hazard is dropped.
//  - RUN, hazard: pc_we=0, ifid_we=0, idex_bubble=1; LU_CYCLES>1 -> LU_STALL, cnt=LU_CYCLES-1.
//  - LU_STALL: same outputs as hazard; cnt-- each cycle; cnt==1 -> RUN. Branch taken here
//    preempts: flush outputs, go FLUSH/RUN as above. dmem wait preempts branch.
//  - FLUSH: pc_we=1, ifid_flush=1, idex_bubble=1; cnt-- ; cnt==1 -> RUN. New branch reloads cnt.
//  - MEM_WAIT: freeze until dmem_ready=1 (that cycle all enables=1, -> RUN). Timeout counter
//    counts wait cycles; reaching MEM_TIMEOUT pulses mem_timeout_err, forces RUN, counter 0.
//  - dmem_req & dmem_ready same cycle in RUN: no wait, evaluate branch/hazard normally.
//  - Counters 4-bit (stall/flush), 8-bit (timeout); no wrap possible given parameter ranges.
// CONFIGURATION
//  HAZARD_CTRL_PERF_EN defined: adds outputs stall_cnt[31:0] (cycles with pc_we=0) and
//  flush_cnt[31:0] (cycles with ifid_flush=1); both reset to 0, saturate at 32'hFFFFFFFF.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 ex_MemRead=1, ex_rt=8, id_rs=8 -> same cycle pc_we=0, ifid_we=0, idex_bubble=1; next RUN.
//  2 ex_MemRead=1, ex_rt=0, id_rs=0 -> no stall; id_uses_rt=0, ex_rt=id_rt=9 -> no stall.
//  3 FLUSH_CYCLES=3, mem_branch_taken 1 cycle -> ifid_flush/idex_bubble high 3 cycles, state 0,2,2,0.
//  4 hazard + mem_branch_taken same cycle -> flush outputs, pc_we=1, no stall.
//  5 dmem_req=1, dmem_ready low 4 cycles -> enables 0 for 4 cycles, 1 on ready; MEM_TIMEOUT=3 -> err pulse cycle 3.
//  6 rst asserted in LU_STALL (LU_CYCLES=4) -> outputs idle immediately; perf counters 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of the hazard controller's pipeline-side inputs and stage controls.
// HAZARD_CTRL_PERF_EN adds the stall_cnt/flush_cnt performance outputs.
interface pipeline_hazard_ctrl_if;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_uses_rt;
   logic        ex_MemRead;
   logic [4:0]  ex_rt;
   logic        mem_branch_taken;
   logic        dmem_req;
   logic        dmem_ready;
   logic        pc_we;
   logic        ifid_we;
   logic        ifid_flush;
   logic        idex_we;
   logic        idex_bubble;
   logic        exmem_bubble;
   logic [1:0]  state;
   logic        mem_timeout_err;
`ifdef HAZARD_CTRL_PERF_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
`endif

   modport master (
`ifdef HAZARD_CTRL_PERF_EN
      input  stall_cnt, flush_cnt,
`endif
      output id_rs, id_rt, id_uses_rt, ex_MemRead, ex_rt,
      output mem_branch_taken, dmem_req, dmem_ready,
      input  pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_bubble,
      input  state, mem_timeout_err
   );

   modport slave (
`ifdef HAZARD_CTRL_PERF_EN
      output stall_cnt, flush_cnt,
`endif
      input  id_rs, id_rt, id_uses_rt, ex_MemRead, ex_rt,
      input  mem_branch_taken, dmem_req, dmem_ready,
      output pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_bubble,
      output state, mem_timeout_err
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ID-stage hazard controller: load-use stalls, branch flushes and data-memory waits.
// Optional HAZARD_CTRL_PERF_EN adds saturating stall/flush cycle counters.
module pipeline_hazard_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned LU_CYCLES    = 1,
   parameter int unsigned MEM_TIMEOUT  = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   pipeline_hazard_ctrl_if.slave  hz
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      FLUSH    = 2'd2,
      MEM_WAIT = 2'd3
   } state_t;

   localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
   localparam logic [3:0] LU_RELOAD    = 4'(LU_CYCLES - 1);
   localparam logic [7:0] TIMEOUT      = 8'(MEM_TIMEOUT);

   state_t     state_r, state_s, wait_state_s;
   logic [3:0] cnt_r, cnt_s;
   logic [7:0] tcnt_r, tcnt_s, wait_cnt_s, wait_tcnt_s;
   logic       hazard_s, mem_stall_s, timeout_hit_s;
   logic       pc_we_s, ifid_we_s, ifid_flush_s, idex_we_s;
   logic       idex_bubble_s, exmem_bubble_s, err_s;

   // Hazard detection and the shared memory-wait bookkeeping.
   always_comb begin
      hazard_s      = hz.ex_MemRead && (hz.ex_rt != 5'd0) &&
                      ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));
      mem_stall_s   = hz.dmem_req && !hz.dmem_ready;
      // The cycle that first detects the wait already counts as wait cycle one.
      wait_cnt_s    = ((state_r == MEM_WAIT) ? tcnt_r : 8'd0) + 8'd1;
      timeout_hit_s = (TIMEOUT != 8'd0) && (wait_cnt_s == TIMEOUT);
      wait_state_s  = timeout_hit_s ? RUN : MEM_WAIT;
      wait_tcnt_s   = (timeout_hit_s || (TIMEOUT == 8'd0)) ? 8'd0 : wait_cnt_s;
   end

   // Next-state and Mealy control outputs.
   always_comb begin
      pc_we_s        = 1'b1;
      ifid_we_s      = 1'b1;
      ifid_flush_s   = 1'b0;
      idex_we_s      = 1'b1;
      idex_bubble_s  = 1'b0;
      exmem_bubble_s = 1'b0;
      err_s          = 1'b0;
      state_s        = state_r;
      cnt_s          = cnt_r;
      tcnt_s         = tcnt_r;
      case (state_r)
         RUN, LU_STALL: begin
            if (mem_stall_s) begin
               pc_we_s   = 1'b0;
               ifid_we_s = 1'b0;
               idex_we_s = 1'b0;
               err_s     = timeout_hit_s;
               state_s   = wait_state_s;
               tcnt_s    = wait_tcnt_s;
               cnt_s     = 4'd0;
            end else if (hz.mem_branch_taken) begin
               ifid_flush_s   = 1'b1;
               idex_bubble_s  = 1'b1;
               exmem_bubble_s = 1'b1;
               if (FLUSH_CYCLES > 32'd1) begin
                  state_s = FLUSH;
                  cnt_s   = FLUSH_RELOAD;
               end else begin
                  state_s = RUN;
                  cnt_s   = 4'd0;
               end
            end else if (state_r == LU_STALL) begin
               pc_we_s       = 1'b0;
               ifid_we_s     = 1'b0;
               idex_bubble_s = 1'b1;
               if (cnt_r <= 4'd1) begin
                  state_s = RUN;
                  cnt_s   = 4'd0;
               end else begin
                  cnt_s = cnt_r - 4'd1;
               end
            end else if (hazard_s) begin
               pc_we_s       = 1'b0;
               ifid_we_s     = 1'b0;
               idex_bubble_s = 1'b1;
               if (LU_CYCLES > 32'd1) begin
                  state_s = LU_STALL;
                  cnt_s   = LU_RELOAD;
               end else begin
                  state_s = RUN;
                  cnt_s   = 4'd0;
               end
            end else begin
               state_s = RUN;
            end
         end
         FLUSH: begin
            ifid_flush_s  = 1'b1;
            idex_bubble_s = 1'b1;
            if (hz.mem_branch_taken) begin
               cnt_s = FLUSH_RELOAD;
            end else if (cnt_r <= 4'd1) begin
               state_s = RUN;
               cnt_s   = 4'd0;
            end else begin
               cnt_s = cnt_r - 4'd1;
            end
         end
         MEM_WAIT: begin
            if (hz.dmem_ready) begin
               state_s = RUN;
               tcnt_s  = 8'd0;
            end else begin
               pc_we_s   = 1'b0;
               ifid_we_s = 1'b0;
               idex_we_s = 1'b0;
               err_s     = timeout_hit_s;
               state_s   = wait_state_s;
               tcnt_s    = wait_tcnt_s;
            end
         end
         default: begin
            state_s = RUN;
            cnt_s   = 4'd0;
            tcnt_s  = 8'd0;
         end
      endcase
   end

   // Outputs are held idle for as long as reset is asserted.
   always_comb begin
      if (rst) begin
         hz.pc_we           = 1'b1;
         hz.ifid_we         = 1'b1;
         hz.ifid_flush      = 1'b0;
         hz.idex_we         = 1'b1;
         hz.idex_bubble     = 1'b0;
         hz.exmem_bubble    = 1'b0;
         hz.mem_timeout_err = 1'b0;
      end else begin
         hz.pc_we           = pc_we_s;
         hz.ifid_we         = ifid_we_s;
         hz.ifid_flush      = ifid_flush_s;
         hz.idex_we         = idex_we_s;
         hz.idex_bubble     = idex_bubble_s;
         hz.exmem_bubble    = exmem_bubble_s;
         hz.mem_timeout_err = err_s;
      end
   end

   assign hz.state = state_r;

   // State and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= RUN;
         cnt_r   <= 4'd0;
         tcnt_r  <= 8'd0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         tcnt_r  <= tcnt_s;
      end
   end

`ifdef HAZARD_CTRL_PERF_EN
   logic [31:0] stall_cnt_r, flush_cnt_r;

   // Saturating performance counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_r <= 32'd0;
         flush_cnt_r <= 32'd0;
      end else begin
         if (!hz.pc_we && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
         if (hz.ifid_flush && (flush_cnt_r != 32'hFFFF_FFFF)) begin
            flush_cnt_r <= flush_cnt_r + 32'd1;
         end else begin
            flush_cnt_r <= flush_cnt_r;
         end
      end
   end

   assign hz.stall_cnt = stall_cnt_r;
   assign hz.flush_cnt = flush_cnt_r;
`endif

endmodule
